// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - digit codes, segment patterns and FSM states for the 7-segment scan decoder
package seg7_pkg;

  // Digit codes beyond 0..9
  localparam logic [3:0] CODE_E     = 4'd10;
  localparam logic [3:0] CODE_R     = 4'd11;
  localparam logic [3:0] CODE_BLANK = 4'd14;
  localparam logic [3:0] CODE_BAD   = 4'd15;

  // Active-low segment patterns, bit6=g .. bit0=a
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_R     = 7'b0101111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_CONV  = 2'd2
  } state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// rtl/seg7_pattern_decode.sv - combinational active-low segment pattern to digit code
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] code
);

  // Map each known glyph to its code; anything else is unknown
  always_comb begin
    code = CODE_BAD;
    case (seg)
      SEG_0:     code = 4'd0;
      SEG_1:     code = 4'd1;
      SEG_2:     code = 4'd2;
      SEG_3:     code = 4'd3;
      SEG_4:     code = 4'd4;
      SEG_5:     code = 4'd5;
      SEG_6:     code = 4'd6;
      SEG_7:     code = 4'd7;
      SEG_8:     code = 4'd8;
      SEG_9:     code = 4'd9;
      SEG_E:     code = CODE_E;
      SEG_R:     code = CODE_R;
      SEG_BLANK: code = CODE_BLANK;
      default:   code = CODE_BAD;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// rtl/seg7_scan_decoder.sv - rebuilds a 4-digit scanned display value; optional SEG7_SCAN_TIMEOUT_EN adds stale detection
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1 << 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  output logic [13:0] value,
  output logic        value_valid,
  output logic        err_shown,
  output logic        frame_error,
  output logic        stale
);

  logic [6:0]       seg_q;
  logic [3:0]       an_q;
  logic [7:0]       stable_cnt;
  logic [3:0]       code;
  logic [1:0]       cap_idx;
  logic             cap_ok;
  logic             capture;
  logic [3:0][3:0]  slot;
  logic [3:0]       seen;
  logic             frame_done;
  logic             timeout_hit;
  logic [3:0][3:0]  snap;
  logic [1:0]       conv_idx;
  logic [13:0]      acc;
  logic [13:0]      acc_next;
  logic             snap_is_err;
  logic             snap_has_bad;
  state_t           state, state_next;
  logic             load_snap, show_err, flag_bad, conv_step, conv_last;

  // Register the bus once and count how long it has held unchanged
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_q      <= '1;
      an_q       <= '1;
      stable_cnt <= '0;
    end else begin
      seg_q <= seg;
      an_q  <= an;
      if ({seg, an} != {seg_q, an_q}) stable_cnt <= '0;
      else if (stable_cnt != 8'hFF)   stable_cnt <= stable_cnt + 8'd1;
    end
  end

  seg7_pattern_decode u_decode (
    .seg  (seg_q),
    .code (code)
  );

  // Only a single low anode identifies a digit position
  always_comb begin
    cap_ok  = 1'b1;
    cap_idx = 2'd0;
    case (an_q)
      4'b1110: cap_idx = 2'd0;
      4'b1101: cap_idx = 2'd1;
      4'b1011: cap_idx = 2'd2;
      4'b0111: cap_idx = 2'd3;
      default: cap_ok  = 1'b0;
    endcase
  end

  assign capture    = cap_ok && (stable_cnt == 8'(SETTLE_CYCLES - 1));
  assign frame_done = (seen == 4'b1111);

  // Slot capture; a capture in the frame-complete cycle starts the next frame
  always_ff @(posedge clk) begin
    if (reset) begin
      seen <= '0;
      slot <= '0;
    end else begin
      seen <= ((frame_done || timeout_hit) ? 4'b0000 : seen) |
              (capture ? (4'b0001 << cap_idx) : 4'b0000);
      if (capture) slot[cap_idx] <= code;
    end
  end

`ifdef SEG7_SCAN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] idle_cnt;

  assign timeout_hit = (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Watchdog on frame completion; expiry flags stale and drops the partial frame
  always_ff @(posedge clk) begin
    if (reset) begin
      idle_cnt <= '0;
      stale    <= 1'b0;
    end else if (frame_done) begin
      idle_cnt <= '0;
      stale    <= 1'b0;
    end else if (timeout_hit) begin
      idle_cnt <= '0;
      stale    <= 1'b1;
    end else begin
      idle_cnt <= idle_cnt + TW'(1);
    end
  end
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT_CYCLES;
  assign timeout_hit    = 1'b0;
  assign stale          = 1'b0;
`endif

  assign snap_is_err  = (snap == {CODE_E, CODE_R, CODE_R, CODE_BLANK});
  assign snap_has_bad = (snap[3] > 4'd9) || (snap[2] > 4'd9) ||
                        (snap[1] > 4'd9) || (snap[0] > 4'd9);
  assign acc_next     = acc * 14'd10 + {10'd0, snap[conv_idx]};

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next state and datapath controls; frames completing while busy are dropped
  always_comb begin
    state_next = state;
    load_snap  = 1'b0;
    show_err   = 1'b0;
    flag_bad   = 1'b0;
    conv_step  = 1'b0;
    conv_last  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (frame_done) begin
          load_snap  = 1'b1;
          state_next = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (snap_is_err) begin
          show_err   = 1'b1;
          state_next = ST_IDLE;
        end else if (snap_has_bad) begin
          flag_bad   = 1'b1;
          state_next = ST_IDLE;
        end else begin
          state_next = ST_CONV;
        end
      end
      ST_CONV: begin
        conv_step = 1'b1;
        if (conv_idx == 2'd0) begin
          conv_last  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Snapshot, BCD-to-binary accumulation (most significant digit first) and outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      snap        <= '0;
      conv_idx    <= 2'd3;
      acc         <= '0;
      value       <= '0;
      value_valid <= 1'b0;
      err_shown   <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      value_valid <= 1'b0;
      frame_error <= flag_bad;
      if (load_snap) begin
        snap     <= slot;
        acc      <= '0;
        conv_idx <= 2'd3;
      end
      if (show_err) err_shown <= 1'b1;
      if (conv_step) begin
        acc      <= acc_next;
        conv_idx <= conv_idx - 2'd1;
      end
      if (conv_last) begin
        value       <= acc_next;
        value_valid <= 1'b1;
        err_shown   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb/tb_seg7_scan_decoder.sv - self-checking bench for seg7_scan_decoder
module tb_seg7_scan_decoder;

  localparam int SETTLE = 16;
  localparam int DWELL  = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  seg = 7'h7F;
  logic [3:0]  an = 4'hF;
  logic [13:0] value;
  logic        value_valid, err_shown, frame_error, stale;

  seg7_scan_decoder #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(1000)) dut (
    .clk         (clk),
    .reset       (reset),
    .seg         (seg),
    .an          (an),
    .value       (value),
    .value_valid (value_valid),
    .err_shown   (err_shown),
    .frame_error (frame_error),
    .stale       (stale)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  int vv_cnt = 0;
  int fe_cnt = 0;

  // Lit segments per digit, active high gfedcba
  logic [6:0] on_mask [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  // Model: digit codes as shown, what each frame must produce, and when
  int  m_slot [4];
  bit  [3:0] m_seen;
  int  m_value;
  bit  m_err;
  int  busy_until;
  int  sched_val [int];
  bit  sched_fe  [int];
  bit  sched_err [int];
  bit  exp_vv, exp_fe;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [6:0] pat_of(input int code);
    logic [6:0] p;
    if (code <= 9)        p = ~on_mask[code];
    else if (code == 10)  p = ~7'h79;
    else if (code == 11)  p = ~7'h50;
    else                  p = 7'h7F;
    return p;
  endfunction

  task automatic model_capture(input int pos, input int code, input int t);
    m_slot[pos] = code;
    m_seen[pos] = 1'b1;
    if (m_seen == 4'hF) begin
      m_seen = 4'h0;
      if (t < busy_until) begin
        bad++;
        $display("FAIL overlap: frame completed at cycle %0d while busy until %0d", t, busy_until);
      end else if (m_slot[3] == 10 && m_slot[2] == 11 && m_slot[1] == 11 && m_slot[0] == 14) begin
        sched_err[t + 2] = 1'b1;
        busy_until = t + 2;
      end else if (m_slot[3] > 9 || m_slot[2] > 9 || m_slot[1] > 9 || m_slot[0] > 9) begin
        sched_fe[t + 2] = 1'b1;
        busy_until = t + 2;
      end else begin
        sched_val[t + 6] = m_slot[3] * 1000 + m_slot[2] * 100 + m_slot[1] * 10 + m_slot[0];
        busy_until = t + 6;
      end
    end
  endtask

  task automatic show(input int pos, input logic [6:0] pat, input int code, input int dwell);
    logic [3:0] one;
    one = 4'b0001 << pos;
    @(posedge clk); #1;
    seg = pat;
    an  = ~one;
    if (dwell >= SETTLE) model_capture(pos, code, cyc + SETTLE + 1);
    repeat (dwell - 1) @(posedge clk);
  endtask

  task automatic scan(input int d3, input int d2, input int d1, input int d0);
    int c [4];
    c = '{d0, d1, d2, d3};
    for (int p = 0; p < 4; p++) show(p, pat_of(c[p]), c[p], DWELL);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    seg = 7'h7F;
    an  = 4'hF;
    for (int i = 0; i < 4; i++) m_slot[i] = 0;
    m_seen = 4'h0;
    m_value = 0;
    m_err = 1'b0;
    busy_until = 0;
    sched_val.delete();
    sched_fe.delete();
    sched_err.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_value", int'(value), 0);
    check("rst_value_valid", int'(value_valid), 0);
    check("rst_err_shown", int'(err_shown), 0);
    check("rst_frame_error", int'(frame_error), 0);
    check("rst_stale", int'(stale), 0);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (!reset) begin
      exp_vv = sched_val.exists(cyc);
      exp_fe = sched_fe.exists(cyc);
      if (exp_vv) begin
        m_value = sched_val[cyc];
        m_err = 1'b0;
      end
      if (sched_err.exists(cyc)) m_err = 1'b1;
      check("value_valid", int'(value_valid), int'(exp_vv));
      check("frame_error", int'(frame_error), int'(exp_fe));
      check("value", int'(value), m_value);
      check("err_shown", int'(err_shown), int'(m_err));
`ifndef SEG7_SCAN_TIMEOUT_EN
      check("stale", int'(stale), 0);
`endif
      if (value_valid) vv_cnt++;
      if (frame_error) fe_cnt++;
    end
  end

  initial begin
    int n;
    do_reset();

    // 1: three frames of 1234
    for (int f = 0; f < 3; f++) scan(1, 2, 3, 4);
    check("t1_value", int'(value), 1234);
    check("t1_vv_count", vv_cnt, 3);
    check("t1_err", int'(err_shown), 0);

    // 2: Err frame, then 0042
    scan(10, 11, 11, 14);
    check("t2_err", int'(err_shown), 1);
    check("t2_value_held", int'(value), 1234);
    check("t2_vv_count", vv_cnt, 3);
    scan(0, 0, 4, 2);
    check("t2_value42", int'(value), 42);
    check("t2_err_clear", int'(err_shown), 0);

    // 3: 9999, short glitch of 8 on digit 1, then the frame finishes with digit 1 last
    scan(9, 9, 9, 9);
    check("t3_value", int'(value), 9999);
    n = vv_cnt;
    show(1, pat_of(8), 8, SETTLE - 1);
    show(0, pat_of(9), 9, DWELL);
    show(2, pat_of(9), 9, DWELL);
    show(3, pat_of(9), 9, DWELL);
    check("t3_glitch_no_frame", vv_cnt, n);
    show(1, pat_of(9), 9, DWELL);
    check("t3_value_after", int'(value), 9999);
    check("t3_vv_count", vv_cnt, n + 1);

    // 4: unknown pattern on digit 2, then 5678
    n = vv_cnt;
    show(0, pat_of(8), 8, DWELL);
    show(1, pat_of(7), 7, DWELL);
    show(2, 7'b1010101, 15, DWELL);
    show(3, pat_of(5), 5, DWELL);
    check("t4_fe_count", fe_cnt, 1);
    check("t4_no_vv", vv_cnt, n);
    check("t4_value_held", int'(value), 9999);
    scan(5, 6, 7, 8);
    check("t4_value", int'(value), 5678);

    // 5: reset after two digits of 4321; the next frame must need all four digits
    show(0, pat_of(1), 1, DWELL);
    show(1, pat_of(2), 2, DWELL);
    do_reset();
    n = vv_cnt;
    show(2, pat_of(3), 3, DWELL);
    show(3, pat_of(4), 4, DWELL);
    check("t5_no_early_frame", vv_cnt, n);
    show(0, pat_of(5), 5, DWELL);
    show(1, pat_of(6), 6, DWELL);
    check("t5_value", int'(value), 4365);
    check("t5_vv_count", vv_cnt, n + 1);

`ifdef SEG7_SCAN_TIMEOUT_EN
    // 6: idle anodes until stale, then a frame clears it
    begin
      int m;
      do_reset();
      m = cyc;
      while (!stale && (cyc - m) < 1200) @(negedge clk);
      check("t6_stale_cycle", cyc - m, 1000);
      check("t6_stale_set", int'(stale), 1);
      scan(1, 2, 3, 4);
      check("t6_stale_clear", int'(stale), 0);
      check("t6_value", int'(value), 1234);
    end
`endif

    repeat (4) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
